dino_game_ctrl: RTL and testbench

- Parametrised next-generation game controller for the Rex runner.
- Owns the game state machine, the dinosaur jump profile, N independently scrolling obstacles, overlap-based collision detection and a saturating score.
- Drives the GPU/renderer position bus and enable; the single button input comes from the board.

---
 rtl/dino_game_ctrl.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_dino_game_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dino_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dino_game_ctrl
// Purpose  : Game controller for the Rex runner. Owns the game state machine,
//            the dinosaur jump profile, N_OBS independently scrolling
//            obstacles, overlap collision detection and a saturating score.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk     in   1            system clock
//   rst     in   1            asynchronous reset, active-high
//   in_up   in   1            jump/start button (level, asynchronous)
//   gpu_en  out  1            renderer enable (high in RUN/JUMP)
//   state   out  2            0 IDLE, 1 RUN, 2 JUMP, 3 OVER
//   dino_y  out  16           dinosaur height offset
//   obs_x   out  N_OBS*X_W    obstacle i x at [i*X_W +: X_W]
//   score   out  16           ticks survived, saturating at 16'hFFFF
//   hit     out  1            one-cycle pulse on the collision entering OVER
// ----------------------------------------------------------------------------
// Build option
//   SPEEDUP_EN : when defined, the obstacle step grows with the score
//                (OBS_STEP + score[15:8], capped at 2*OBS_STEP).
// ============================================================================
module dino_game_ctrl #(
  parameter int N_OBS     = 2,
  parameter int X_W       = 16,
  parameter int DIV       = 50,
  parameter int OBS_STEP  = 8,
  parameter int SPAWN_X   = 240,
  parameter int SPACING   = 120,
  parameter int DESPAWN_X = 10,
  parameter int OBS_W     = 16,
  parameter int OBS_H     = 26,
  parameter int DINO_XL   = 16,
  parameter int DINO_XR   = 32,
  parameter int H1        = 15,
  parameter int H2        = 27,
  parameter int H3        = 34,
  parameter int H4        = 36
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_up,
  output logic                 gpu_en,
  output logic [1:0]           state,
  output logic [15:0]          dino_y,
  output logic [N_OBS*X_W-1:0] obs_x,
  output logic [15:0]          score,
  output logic                 hit
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_JUMP = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam int             c_div_w   = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam logic [c_div_w-1:0] c_div_max = c_div_w'(DIV);
  localparam logic [X_W-1:0] c_despawn = X_W'(DESPAWN_X);
  localparam logic [X_W-1:0] c_spawn   = X_W'(SPAWN_X);
  localparam logic [X_W-1:0] c_dino_xr = X_W'(DINO_XR);
  localparam logic [X_W:0]   c_dino_xl = (X_W + 1)'(DINO_XL);
  localparam logic [X_W:0]   c_obs_w   = (X_W + 1)'(OBS_W);
  localparam logic [15:0]    c_obs_h   = 16'(OBS_H);
  localparam logic [15:0]    c_h1      = 16'(H1);
  localparam logic [15:0]    c_h2      = 16'(H2);
  localparam logic [15:0]    c_h3      = 16'(H3);
  localparam logic [15:0]    c_h4      = 16'(H4);

  // Registered state
  state_t               r_state;
  logic                 r_meta;
  logic                 r_q0;
  logic                 r_q1;
  logic [c_div_w-1:0]   r_div;
  logic [2:0]           r_level;
  logic                 r_up;
  logic [15:0]          r_dino_y;
  logic [X_W-1:0]       r_obs [N_OBS];
  logic [15:0]          r_score;
  logic                 r_hit;

  // Next-state values
  state_t               w_state_nxt;
  logic [c_div_w-1:0]   w_div_nxt;
  logic [2:0]           w_level_nxt;
  logic                 w_up_nxt;
  logic [15:0]          w_dino_nxt;
  logic [X_W-1:0]       w_obs_nxt [N_OBS];
  logic [15:0]          w_score_nxt;
  logic                 w_hit_nxt;

  logic                 w_press;
  logic                 w_active;
  logic                 w_tick;
  logic                 w_collide;
  logic [X_W-1:0]       w_step;

  // Reload position of obstacle channel i.
  function automatic logic [X_W-1:0] f_obs_init(input int idx);
    return X_W'(SPAWN_X + idx * SPACING);
  endfunction

  // Jump height for a given profile level; level 0 is the ground.
  function automatic logic [15:0] f_height(input logic [2:0] lvl);
    case (lvl)
      3'd1:    return c_h1;
      3'd2:    return c_h2;
      3'd3:    return c_h3;
      3'd4:    return c_h4;
      default: return 16'd0;
    endcase
  endfunction

  // r_meta absorbs metastability of the asynchronous button; q0/q1 then
  // form the edge detector so a held button yields exactly one press.
  assign w_press  = r_q0 & ~r_q1;
  assign w_active = (r_state == ST_RUN) || (r_state == ST_JUMP);
  assign w_tick   = w_active && (r_div == c_div_max);

`ifdef SPEEDUP_EN
  localparam logic [X_W+8:0] c_step_base = (X_W + 9)'(OBS_STEP);
  localparam logic [X_W+8:0] c_step_cap  = (X_W + 9)'(2 * OBS_STEP);
  logic [X_W+8:0] w_step_sum;

  always_comb begin
    w_step_sum = c_step_base + (X_W + 9)'(r_score[15:8]);
    w_step     = (w_step_sum > c_step_cap) ? c_step_cap[X_W-1:0]
                                           : w_step_sum[X_W-1:0];
  end
`else
  assign w_step = X_W'(OBS_STEP);
`endif

  // Overlap test on registered positions; the X_W+1 sum keeps x+OBS_W from
  // wrapping near the top of the coordinate range.
  always_comb begin
    w_collide = 1'b0;
    if (w_active && (r_dino_y < c_obs_h)) begin
      for (int i = 0; i < N_OBS; i++) begin
        if ((r_obs[i] < c_dino_xr) &&
            (({1'b0, r_obs[i]} + c_obs_w) > c_dino_xl)) begin
          w_collide = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_level_nxt = r_level;
    w_up_nxt    = r_up;
    w_dino_nxt  = r_dino_y;
    w_score_nxt = r_score;
    w_hit_nxt   = 1'b0;
    for (int i = 0; i < N_OBS; i++) begin
      w_obs_nxt[i] = r_obs[i];
    end

    if (w_collide) begin
      // Collision wins over any same-cycle tick or press: everything freezes.
      w_state_nxt = ST_OVER;
      w_hit_nxt   = 1'b1;
      w_div_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_press) begin
            w_state_nxt = ST_RUN;
            w_score_nxt = 16'd0;
            w_div_nxt   = '0;
          end
        end

        ST_RUN, ST_JUMP: begin
          w_div_nxt = w_tick ? '0 : r_div + c_div_w'(1);

          if (w_tick) begin
            if (r_score != 16'hFFFF) begin
              w_score_nxt = r_score + 16'd1;
            end
            // Despawn test happens before the subtraction, so x never
            // underflows for legal parameter sets.
            for (int i = 0; i < N_OBS; i++) begin
              if (r_obs[i] < c_despawn) begin
                w_obs_nxt[i] = c_spawn;
              end else begin
                w_obs_nxt[i] = r_obs[i] - w_step;
              end
            end
          end

          if (r_state == ST_RUN) begin
            if (w_press) begin
              w_state_nxt = ST_JUMP;
              w_level_nxt = 3'd0;
              w_up_nxt    = 1'b1;
            end
          end else if (w_tick) begin
            // Profile climbs 0->4 then descends 4->0; landing returns to RUN.
            if (r_up) begin
              w_level_nxt = r_level + 3'd1;
              if (r_level == 3'd3) begin
                w_up_nxt = 1'b0;
              end
            end else begin
              w_level_nxt = r_level - 3'd1;
              if (r_level == 3'd1) begin
                w_state_nxt = ST_RUN;
              end
            end
            w_dino_nxt = f_height(w_level_nxt);
          end
        end

        ST_OVER: begin
          if (w_press) begin
            w_state_nxt = ST_IDLE;
            w_dino_nxt  = 16'd0;
            w_level_nxt = 3'd0;
            w_up_nxt    = 1'b0;
            w_div_nxt   = '0;
            for (int i = 0; i < N_OBS; i++) begin
              w_obs_nxt[i] = f_obs_init(i);
            end
          end
        end

        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta   <= 1'b0;
      r_q0     <= 1'b0;
      r_q1     <= 1'b0;
      r_state  <= ST_IDLE;
      r_div    <= '0;
      r_level  <= 3'd0;
      r_up     <= 1'b0;
      r_dino_y <= 16'd0;
      r_score  <= 16'd0;
      r_hit    <= 1'b0;
      for (int i = 0; i < N_OBS; i++) begin
        r_obs[i] <= f_obs_init(i);
      end
    end else begin
      r_meta   <= in_up;
      r_q0     <= r_meta;
      r_q1     <= r_q0;
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_level  <= w_level_nxt;
      r_up     <= w_up_nxt;
      r_dino_y <= w_dino_nxt;
      r_score  <= w_score_nxt;
      r_hit    <= w_hit_nxt;
      for (int i = 0; i < N_OBS; i++) begin
        r_obs[i] <= w_obs_nxt[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_OBS; gi++) begin : g_obs_out
      assign obs_x[gi*X_W +: X_W] = r_obs[gi];
    end
  endgenerate

  assign state  = r_state;
  assign gpu_en = w_active;
  assign dino_y = r_dino_y;
  assign score  = r_score;
  assign hit    = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_dino_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dino_game_ctrl
// Purpose  : Self-checking bench for dino_game_ctrl. A game-level reference
//            model (jump profile table, obstacle list, integer score) is
//            stepped once per clock and compared against the DUT; a second
//            instance with DIV=0 exercises score saturation and speed-up.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dino_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_up;
  logic        gpu_en;
  logic [1:0]  state;
  logic [15:0] dino_y;
  logic [31:0] obs_x;
  logic [15:0] score;
  logic        hit;

  logic        rst2;
  logic        in_up2;
  logic        gpu_en2;
  logic [1:0]  state2;
  logic [15:0] dino_y2;
  logic [15:0] obs_x2;
  logic [15:0] score2;
  logic        hit2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dino_game_ctrl #(.N_OBS(2), .DIV(3)) dut (
    .clk(clk), .rst(rst), .in_up(in_up), .gpu_en(gpu_en), .state(state),
    .dino_y(dino_y), .obs_x(obs_x), .score(score), .hit(hit)
  );

  // Obstacles can never reach the dinosaur here, so the game runs forever.
  dino_game_ctrl #(.N_OBS(1), .DIV(0), .DESPAWN_X(20), .DINO_XL(0),
                   .DINO_XR(2)) dut2 (
    .clk(clk), .rst(rst2), .in_up(in_up2), .gpu_en(gpu_en2), .state(state2),
    .dino_y(dino_y2), .obs_x(obs_x2), .score(score2), .hit(hit2)
  );

  // ---------------- reference model (instance 1) ----------------
  int prof [9] = '{0, 15, 27, 34, 36, 34, 27, 15, 0};
  int m_st, m_phase, m_dy, m_score, m_div;
  int m_obs [2];
  bit m_hit;
  bit p1, p2, p3;   // button samples from 1, 2 and 3 edges ago

  function automatic int step_for(input int s, input int base);
    int st;
    st = base;
`ifdef SPEEDUP_EN
    st = base + (s >> 8);
    if (st > 2 * base) st = 2 * base;
`endif
    return st;
  endfunction

  task automatic model_reset();
    m_st = 0; m_phase = 0; m_dy = 0; m_score = 0; m_div = 0; m_hit = 0;
    m_obs[0] = 240; m_obs[1] = 360;
    p1 = 0; p2 = 0; p3 = 0;
  endtask

  task automatic model_step(input bit cur);
    bit press, running, tick, col;
    int st;
    press   = p2 && !p3;
    running = (m_st == 1) || (m_st == 2);
    tick    = running && (m_div == 3);
    col = 0;
    if (running && m_dy < 26)
      for (int i = 0; i < 2; i++)
        if (m_obs[i] < 32 && m_obs[i] + 16 > 16) col = 1;
    m_hit = col;
    if (col) begin
      m_st = 3;
    end else if (m_st == 0) begin
      if (press) begin m_st = 1; m_score = 0; m_div = 0; end
    end else if (running) begin
      if (tick) begin
        m_div = 0;
        st = step_for(m_score, 8);
        for (int i = 0; i < 2; i++)
          m_obs[i] = (m_obs[i] < 10) ? 240 : m_obs[i] - st;
        if (m_score < 65535) m_score++;
      end else begin
        m_div++;
      end
      if (m_st == 1) begin
        if (press) begin m_st = 2; m_phase = 0; end
      end else if (tick) begin
        m_phase++;
        m_dy = prof[m_phase];
        if (m_phase == 8) m_st = 1;
      end
    end else begin
      if (press) begin
        m_st = 0; m_dy = 0; m_obs[0] = 240; m_obs[1] = 360;
      end
    end
    p3 = p2; p2 = p1; p1 = cur;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("state",  64'(state),        64'(m_st));
    chk("dino_y", 64'(dino_y),       64'(m_dy));
    chk("obs0",   64'(obs_x[15:0]),  64'(m_obs[0]));
    chk("obs1",   64'(obs_x[31:16]), 64'(m_obs[1]));
    chk("score",  64'(score),        64'(m_score));
    chk("hit",    64'(hit),          64'(m_hit));
    chk("gpu_en", 64'(gpu_en),       64'((m_st == 1) || (m_st == 2)));
  endtask

  task automatic cycle(input bit v);
    @(negedge clk);
    in_up = v;
    @(posedge clk);
    model_step(v);
    #1;
    compare_all();
  endtask

  initial begin
    bit   v;
    int   hold;
    bit   found;
    int   prev_x, prev_s;

    rst = 1'b1; in_up = 1'b0; rst2 = 1'b1; in_up2 = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Start the game with a long hold: exactly one press, no repeat jump.
    repeat (4)  cycle(1'b0);
    repeat (20) cycle(1'b1);
    repeat (4)  cycle(1'b0);
    // Single jump from RUN, then let it land.
    repeat (3)  cycle(1'b1);
    repeat (50) cycle(1'b0);

    // Random button activity across all game states.
    v = 1'b0;
    for (int n = 0; n < 2500; n++) begin
      if (hold == 0) begin
        v    = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 8);
      end
      hold--;
      cycle(v);
    end

    // Drive periodic presses until mid-jump at height 27, then reset async.
    found = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      cycle((n % 6) < 3);
      if (m_st == 2 && m_dy == 27) found = 1'b1;
    end
    chk("reach_jump27", 64'(found), 64'(1));
    #1;
    rst = 1'b1;
    #1;
    chk("arst_state",  64'(state),         64'(0));
    chk("arst_dino_y", 64'(dino_y),        64'(0));
    chk("arst_obs0",   64'(obs_x[15:0]),   64'(240));
    chk("arst_obs1",   64'(obs_x[31:16]),  64'(360));
    chk("arst_score",  64'(score),         64'(0));
    chk("arst_gpu_en", 64'(gpu_en),        64'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_up = 1'b0;
    hold = 0;
    for (int n = 0; n < 500; n++) begin
      if (hold == 0) begin
        v    = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 6);
      end
      hold--;
      cycle(v);
    end

    // Saturation: DIV=0 ticks every cycle once running.
    @(negedge clk);
    rst2 = 1'b0;
    in_up2 = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 8 && !found; n++) begin
      @(posedge clk);
      #1;
      if (state2 == 2'd1) found = 1'b1;
    end
    chk("start2", 64'(state2), 64'(1));
    chk("start2_score", 64'(score2), 64'(0));
    in_up2 = 1'b0;
    for (int k = 1; k <= 65536; k++) begin
      prev_x = int'(obs_x2);
      prev_s = int'(score2);
      @(posedge clk);
      #1;
      if (k == 100)   chk("score_100",  64'(score2), 64'(100));
      if (k == 65534) chk("score_fffe", 64'(score2), 64'(16'hFFFE));
      if (k == 65535) chk("score_ffff", 64'(score2), 64'(16'hFFFF));
      if (k == 65536) chk("score_hold", 64'(score2), 64'(16'hFFFF));
      if (prev_s >= 'h300 && prev_s < 'h304 && prev_x >= 20)
        chk("step_at_0x300", 64'(prev_x - int'(obs_x2)),
            64'(step_for(prev_s, 8)));
    end
    chk("run2_state", 64'(state2), 64'(1));
    chk("run2_hit",   64'(hit2),   64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
